reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, default 64: number of tracked architectural registers.
REQ-002 SHALL have parameter RN_W, default 7: register-number field width.
REQ-003 SHALL have parameter NISSUE, default 2: issue (mark-busy) ports.
REQ-004 SHALL have parameter NFREE, default 2: writeback (free) ports.
REQ-005 SHALL have parameter CNT_W, default 2: per-register outstanding-write counter width; max outstanding = 2^CNT_W-1.
REQ-006 SHALL have parameter UNIT_W, default 3: execution-unit ID width (used only under REQ-027).
REQ-007 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-008 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port issue_en, input, NISSUE: per-port issue request.
REQ-010 SHALL have port issue_rn, input, NISSUE*RN_W: packed destination numbers, port k at bits [k*RN_W +: RN_W].
REQ-011 SHALL have port issue_unit, input, NISSUE*UNIT_W: packed issuing-unit IDs.
REQ-012 SHALL have port free_en, input, NFREE: per-port writeback-complete strobe.
REQ-013 SHALL have port free_rn, input, NFREE*RN_W: packed freed register numbers.
REQ-014 SHALL have port reg_busy, output, NREGS: registered, bit r = 1 iff counter[r] != 0.
REQ-015 SHALL have port issue_stall, output, 1: combinational; high when any enabled issue would overflow its counter.
REQ-016 SHALL have port free_err, output, 1: sticky, registered underflow flag.
REQ-017 SHALL have port owner_rn, input, RN_W; port owner_unit, output, UNIT_W: owner query (REQ-027).

Function
REQ-018 Each register r SHALL keep a CNT_W-bit counter; next = cur + (enabled issues to r) - (enabled frees to r), evaluated over all ports in the same cycle.
REQ-019 Register 0 and any rn >= NREGS SHALL be ignored on every port; reg_busy[0] stays 0.
REQ-020 Multiple issue ports naming the same register in one cycle SHALL each count (two issues to r3 -> +2).
REQ-021 Issue and free of the same register in one cycle SHALL net out; counter unchanged, reg_busy unchanged.
REQ-022 issue_stall SHALL assert when, for any r, cur + issues(r) - frees(r) > 2^CNT_W-1; while asserted, no issue port SHALL update any counter (all-or-nothing); frees still apply.
REQ-023 A free driving a counter below zero SHALL clamp that counter at 0 and set free_err to 1 on the next edge; free_err clears only on reset.
REQ-024 reg_busy SHALL reflect the updated counters one clock after the issue/free edge (latency 1).
REQ-025 issue_stall SHALL have zero-cycle latency from issue_en/issue_rn/free inputs.

Reset
REQ-026 On rst_n low, asynchronously: all counters 0, reg_busy 0, free_err 0, owner table 0; issues/frees in the reset cycle SHALL be discarded; issue_stall SHALL be 0 while in reset.

Configuration
REQ-027 Macro RAISIN64_SB_OWNER_EN: when defined, each register SHALL store the issue_unit of its most recent accepted issue (highest-numbered port wins on same-cycle collision), and owner_unit SHALL combinationally return the entry for owner_rn (0 for r0/out-of-range); when undefined, no owner storage SHALL be built, issue_unit SHALL be ignored, owner_unit SHALL be tied to 0.

Verification
REQ-028 Reset, then issue_en=01, issue_rn[0]=5 -> next cycle reg_busy[5]=1; free_rn[0]=5 one cycle later -> reg_busy[5]=0.
REQ-029 Issue r7 on both ports same cycle, then free r7 once -> reg_busy[7] stays 1; second free -> 0; free_err stays 0.
REQ-030 CNT_W=2: three issues to r9 accepted, fourth issue to r9 -> issue_stall=1 that cycle, counter stays 3, concurrent issue to r10 also blocked; same cycle with free r9 -> no stall, count 3.
REQ-031 Issue r0 and r70 (NREGS=64) -> reg_busy stays 0; free r12 while idle -> free_err=1 next cycle, reg_busy[12]=0.
REQ-032 Issue r4 and free r4 same cycle while count 1 -> count stays 1, reg_busy[4]=1.
REQ-033 With RAISIN64_SB_OWNER_EN: issue r6 unit 3 on port 0 and unit 5 on port 1 -> owner_rn=6 gives owner_unit=5; assert rst_n mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register outstanding-write counters with
// multi-port issue (mark busy) and writeback (free), overflow stall,
// sticky underflow flag and an optional owner-unit table.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   issue_en/rn/unit  NISSUE packed issue ports (dest reg, unit id)
//   free_en/rn        NFREE packed writeback ports
//   reg_busy          registered busy vector, bit r = counter[r] != 0
//   issue_stall       combinational, any enabled issue would overflow
//   free_err          sticky underflow flag, cleared only by reset
//   owner_rn/unit     owner query (live only with RAISIN64_SB_OWNER_EN)
//
// Build option: define RAISIN64_SB_OWNER_EN to build the owner table.
// Register 0 and rn >= NREGS are ignored on every port.
module reg_scoreboard #(
  parameter int NREGS  = 64,
  parameter int RN_W   = 7,
  parameter int NISSUE = 2,
  parameter int NFREE  = 2,
  parameter int CNT_W  = 2,
  parameter int UNIT_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NISSUE-1:0]        issue_en,
  input  logic [NISSUE*RN_W-1:0]   issue_rn,
  input  logic [NISSUE*UNIT_W-1:0] issue_unit,
  input  logic [NFREE-1:0]         free_en,
  input  logic [NFREE*RN_W-1:0]    free_rn,
  output logic [NREGS-1:0]         reg_busy,
  output logic                     issue_stall,
  output logic                     free_err,
  input  logic [RN_W-1:0]          owner_rn,
  output logic [UNIT_W-1:0]        owner_unit
);

  localparam int MAXC = (1 << CNT_W) - 1;

  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             err_q;
  logic             err_d;

  int   inc_c [NREGS];
  int   dec_c [NREGS];
  logic ovf_c;
  logic udf_c;

  // Per-register issue/free tallies across all ports this cycle.
  // r starts matching at 1 so register 0 never accumulates.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      inc_c[r] = 0;
      dec_c[r] = 0;
    end
    for (int k = 0; k < NISSUE; k++) begin
      for (int r = 1; r < NREGS; r++) begin
        if (issue_en[k] &&
            int'(issue_rn[k*RN_W +: RN_W]) == r)
          inc_c[r] = inc_c[r] + 1;
      end
    end
    for (int k = 0; k < NFREE; k++) begin
      for (int r = 1; r < NREGS; r++) begin
        if (free_en[k] &&
            int'(free_rn[k*RN_W +: RN_W]) == r)
          dec_c[r] = dec_c[r] + 1;
      end
    end
  end

  // Overflow test uses the net count so a same-cycle free
  // can make room for an issue.
  always_comb begin
    ovf_c = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      if (int'(cnt_q[r]) + inc_c[r] - dec_c[r] > MAXC)
        ovf_c = 1'b1;
    end
  end

  assign issue_stall = rst_n & ovf_c;

  // Stall drops every issue; frees still apply and clamp at 0.
  always_comb begin
    int t;
    t      = 0;
    udf_c  = 1'b0;
    busy_d = '0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = '0;
    end
    for (int r = 1; r < NREGS; r++) begin
      t = int'(cnt_q[r]) - dec_c[r];
      if (!ovf_c)
        t = t + inc_c[r];
      if (t < 0) begin
        t     = 0;
        udf_c = 1'b1;
      end
      cnt_d[r]  = CNT_W'(t);
      busy_d[r] = (t != 0);
    end
    err_d = err_q | udf_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= '0;
      end
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign reg_busy = busy_q;
  assign free_err = err_q;

`ifdef RAISIN64_SB_OWNER_EN
  logic [UNIT_W-1:0] own_q [NREGS];
  logic [UNIT_W-1:0] own_d [NREGS];

  // Ascending port walk: highest port wins a collision.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      own_d[r] = own_q[r];
    end
    if (!ovf_c) begin
      for (int k = 0; k < NISSUE; k++) begin
        for (int r = 1; r < NREGS; r++) begin
          if (issue_en[k] &&
              int'(issue_rn[k*RN_W +: RN_W]) == r)
            own_d[r] = issue_unit[k*UNIT_W +: UNIT_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        own_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        own_q[r] <= own_d[r];
      end
    end
  end

  always_comb begin
    owner_unit = '0;
    for (int r = 1; r < NREGS; r++) begin
      if (int'(owner_rn) == r)
        owner_unit = own_q[r];
    end
  end
`else
  logic unused_owner;
  assign unused_owner = ^{issue_unit, owner_rn};
  assign owner_unit   = '0;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized scoreboard bench for reg_scoreboard with a
// count-per-register reference model and a queue-driven monitor.
module tb_reg_scoreboard;

  localparam int NR = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  issue_en = '0;
  logic [13:0] issue_rn = '0;
  logic [5:0]  issue_unit = '0;
  logic [1:0]  free_en = '0;
  logic [13:0] free_rn = '0;
  logic [6:0]  owner_rn = '0;
  logic [63:0] reg_busy;
  logic        issue_stall;
  logic        free_err;
  logic [2:0]  owner_unit;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_en   (issue_en),
    .issue_rn   (issue_rn),
    .issue_unit (issue_unit),
    .free_en    (free_en),
    .free_rn    (free_rn),
    .reg_busy   (reg_busy),
    .issue_stall(issue_stall),
    .free_err   (free_err),
    .owner_rn   (owner_rn),
    .owner_unit (owner_unit)
  );

  typedef struct {
    logic [63:0] busy;
    logic        err;
    logic [2:0]  own;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   m_cnt[NR];
  int   m_own[NR];
  bit   m_err;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic bit vld(int rn);
    return rn > 0 && rn < NR;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_cnt[r] = 0;
      m_own[r] = 0;
    end
    m_err = 0;
    q.delete();
  endtask

  // Called at a negedge; drives one cycle, predicts, returns at next negedge.
  task automatic step(logic [1:0] ien, int i0, int i1,
                      logic [1:0] fen, int f0, int f1,
                      int u0 = 0, int u1 = 0, int orn = 0);
    int   ni[NR];
    int   nf[NR];
    bit   st;
    int   t;
    exp_t e;
    issue_en   = ien;
    issue_rn   = {7'(i1), 7'(i0)};
    free_en    = fen;
    free_rn    = {7'(f1), 7'(f0)};
    issue_unit = {3'(u1), 3'(u0)};
    owner_rn   = 7'(orn);
    for (int r = 0; r < NR; r++) begin
      ni[r] = 0;
      nf[r] = 0;
    end
    if (ien[0] && vld(i0)) ni[i0]++;
    if (ien[1] && vld(i1)) ni[i1]++;
    if (fen[0] && vld(f0)) nf[f0]++;
    if (fen[1] && vld(f1)) nf[f1]++;
    st = 0;
    for (int r = 0; r < NR; r++)
      if (m_cnt[r] + ni[r] - nf[r] > 3) st = 1;
    #1;
    chk("issue_stall", 64'(issue_stall), 64'(st));
    for (int r = 0; r < NR; r++) begin
      t = m_cnt[r] - nf[r] + (st ? 0 : ni[r]);
      if (t < 0) begin
        t = 0;
        m_err = 1;
      end
      m_cnt[r] = t;
    end
`ifdef RAISIN64_SB_OWNER_EN
    if (!st) begin
      if (ien[0] && vld(i0)) m_own[i0] = u0;
      if (ien[1] && vld(i1)) m_own[i1] = u1;
    end
`endif
    e.busy = '0;
    for (int r = 0; r < NR; r++)
      e.busy[r] = (m_cnt[r] != 0);
    e.err = m_err;
    e.own = vld(orn) ? 3'(m_own[orn]) : 3'd0;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(int orn = 0);
    step(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, orn);
  endtask

  // Async reset asserted between edges with traffic on the inputs.
  task automatic mid_reset();
    issue_en = 2'b11;
    issue_rn = {7'd3, 7'd3};
    free_en  = 2'b01;
    free_rn  = {7'd0, 7'd12};
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", reg_busy, 64'd0);
    chk("rst_err", 64'(free_err), 64'd0);
    chk("rst_stall", 64'(issue_stall), 64'd0);
    chk("rst_owner", 64'(owner_unit), 64'd0);
    model_reset();
    @(negedge clk);
    chk("rst_hold_busy", reg_busy, 64'd0);
    rst_n    = 1'b1;
    issue_en = '0;
    free_en  = '0;
  endtask

  function automatic int rnd_rn();
    int p;
    p = int'($urandom_range(0, 99));
    if (p < 80) return int'($urandom_range(0, 15));
    if (p < 90) return int'($urandom_range(60, 70));
    return int'($urandom_range(0, 127));
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        chk("reg_busy", reg_busy, e.busy);
        chk("free_err", 64'(free_err), 64'(e.err));
        chk("owner_unit", 64'(owner_unit), 64'(e.own));
      end
    end
  end

  initial begin : driver
    model_reset();
    issue_en = 2'b11;
    issue_rn = {7'd9, 7'd9};
    @(negedge clk);
    #1;
    chk("init_busy", reg_busy, 64'd0);
    chk("init_err", 64'(free_err), 64'd0);
    chk("init_stall", 64'(issue_stall), 64'd0);
    chk("init_owner", 64'(owner_unit), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // single issue then free
    step(2'b01, 5, 0, 2'b00, 0, 0);
    step(2'b00, 0, 0, 2'b01, 5, 0);
    idle();
    // double issue same reg, two frees
    step(2'b11, 7, 7, 2'b00, 0, 0);
    step(2'b00, 0, 0, 2'b01, 7, 0);
    step(2'b00, 0, 0, 2'b10, 0, 7);
    // saturate r9, overflow blocks r10 too, then freed slot
    step(2'b11, 9, 9, 2'b00, 0, 0);
    step(2'b01, 9, 0, 2'b00, 0, 0);
    step(2'b11, 9, 10, 2'b00, 0, 0);
    step(2'b01, 9, 0, 2'b01, 9, 0);
    step(2'b00, 0, 0, 2'b11, 9, 9);
    step(2'b00, 0, 0, 2'b01, 9, 0);
    idle();
    // same-cycle issue/free nets out at count 1
    step(2'b01, 4, 0, 2'b00, 0, 0);
    step(2'b01, 4, 0, 2'b01, 4, 0);
    step(2'b00, 0, 0, 2'b01, 4, 0);
    // ignored registers, then underflow
    step(2'b11, 0, 70, 2'b00, 0, 0);
    step(2'b00, 0, 0, 2'b01, 12, 0);
    idle(12);
    mid_reset();
    // owner collision: port 1 wins
    step(2'b11, 6, 6, 2'b00, 0, 0, 3, 5, 6);
    idle(6);
    step(2'b01, 6, 0, 2'b00, 0, 0, 2, 0, 6);
    idle(0);
    mid_reset();
    for (int n = 0; n < 1500; n++) begin
      if (n % 500 == 499) mid_reset();
      step(2'($urandom_range(0, 3)), rnd_rn(), rnd_rn(),
           2'($urandom_range(0, 3)), rnd_rn(), rnd_rn(),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           rnd_rn());
    end
    issue_en = '0;
    free_en  = '0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
